// File: rtl/csa_final_adder_pkg.sv
// Shared types and helpers for the segmented carry-save final adder.
package csa_final_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_seg(input int output_width, input int seg_width);
        return (output_width + seg_width - 1) / seg_width;
    endfunction

endpackage

// File: rtl/csa_final_adder_seg_adder.sv
// Combinational SegWidth-bit adder with carry in/out, reused every ADD cycle.
module seg_adder #(
    parameter int SegWidth = 8
) (
    input  logic [SegWidth-1:0] a_i,
    input  logic [SegWidth-1:0] b_i,
    input  logic                cin_i,
    output logic [SegWidth-1:0] sum_o,
    output logic                cout_o
);

    assign {cout_o, sum_o} = (SegWidth+1)'(a_i) + (SegWidth+1)'(b_i) + (SegWidth+1)'(cin_i);

endmodule

// File: rtl/csa_final_adder.sv
// Resolves a carry-save pair into a binary sum, SegWidth bits per cycle,
// with valid/ready handshakes on both sides.
module csa_final_adder
    import csa_final_adder_pkg::*;
#(
    parameter int OutputWidth = 16,
    parameter int SegWidth    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OutputWidth-1:0] vector0,
    input  logic [OutputWidth-1:0] vector1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OutputWidth-1:0] sum,
    output logic                   carry_out
);

    localparam int NumSeg = num_seg(OutputWidth, SegWidth);
    localparam int CntW   = $clog2(NumSeg + 1);
    localparam int LastW  = OutputWidth - (NumSeg - 1) * SegWidth;
    localparam int ExtW   = OutputWidth + SegWidth;
    localparam logic [CntW-1:0] LastSeg = CntW'(NumSeg - 1);

    state_e                 state_q, state_d;
    logic [OutputWidth-1:0] op0_q, op0_d, op1_q, op1_d;
    logic [OutputWidth-1:0] sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    // Zero-extended views let the partial top segment use the same part-select.
    logic [ExtW-1:0]     op0_ext, op1_ext, sum_ext;
    logic [SegWidth-1:0] seg_a, seg_b, seg_s;
    logic                seg_c;
    logic                unused_sum_hi;
    int                  base;

    always_comb begin
        base    = int'(cnt_q) * SegWidth;
        op0_ext = ExtW'(op0_q);
        op1_ext = ExtW'(op1_q);
        seg_a   = op0_ext[base +: SegWidth];
        seg_b   = op1_ext[base +: SegWidth];
        sum_ext = ExtW'(sum_q);
        sum_ext[base +: SegWidth] = seg_s;
    end

    assign unused_sum_hi = ^sum_ext[ExtW-1:OutputWidth];

    seg_adder #(.SegWidth(SegWidth)) u_seg_adder (
        .a_i    (seg_a),
        .b_i    (seg_b),
        .cin_i  (carry_q),
        .sum_o  (seg_s),
        .cout_o (seg_c)
    );

    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op0_d   = vector0;
                    op1_d   = vector1;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sum_ext[OutputWidth-1:0];
                carry_d = seg_c;
                if (cnt_q == LastSeg) begin
                    // In a partial top segment the carry out of bit OutputWidth-1
                    // lands in the first padding bit of the segment sum.
                    cout_d  = (LastW == SegWidth) ? seg_c : seg_s[LastW % SegWidth];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule
